sample_div_seq_s11_u6: RTL and testbench

Sequential signed-by-unsigned divider that reverses the 6-bit-unsigned × 11-bit-signed multiply used in the sample datapath. It recovers a quotient and remainder from an 11-bit signed dividend and a 6-bit unsigned divisor. It uses restoring division, producing one quotient bit per cycle, behind a start/done handshake. Clock-enable gating matches the existing multiplier cores, so it drops into the same HLS-style pipeline control.

---
 rtl/sample_div_seq_s11_u6_if.sv | 27 ++
 rtl/sample_div_seq_s11_u6.sv | 110 +++++++++++
 tb/tb_sample_div_seq_s11_u6.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sample_div_seq_s11_u6_if.sv
// Operand/result bundle for the sequential signed-by-unsigned divider.
// Handshake: start is taken only on a ce cycle with ready=1; done pulses once per divide.
interface sample_div_seq_s11_u6_if #(
   parameter int DIVIDEND_WIDTH = 11,
   parameter int DIVISOR_WIDTH  = 6
);
   logic                      ce;
   logic                      start;
   logic [DIVIDEND_WIDTH-1:0] din0;
   logic [DIVISOR_WIDTH-1:0]  din1;
   logic                      ready;
   logic                      done;
   logic [DIVIDEND_WIDTH-1:0] quot;
   logic [DIVISOR_WIDTH:0]    rem;
   logic                      div_by_zero;
   logic [1:0]                state_dbg;

   modport master (
      output ce, start, din0, din1,
      input  ready, done, quot, rem, div_by_zero, state_dbg
   );

   modport slave (
      input  ce, start, din0, din1,
      output ready, done, quot, rem, div_by_zero, state_dbg
   );
endinterface

// File: rtl/sample_div_seq_s11_u6.sv
// Restoring divider: signed dividend by unsigned divisor, one quotient bit per ce cycle.
// Works on magnitudes and restores signs in FIXUP; quotient truncates toward zero.
module sample_div_seq_s11_u6 #(
   parameter int DIVIDEND_WIDTH = 11,
   parameter int DIVISOR_WIDTH  = 6
) (
   input  logic clk,
   input  logic reset,
   sample_div_seq_s11_u6_if.slave bus
);
   localparam int W  = DIVIDEND_WIDTH;
   localparam int D  = DIVISOR_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t         state, state_next;
   logic [W-1:0]   mag, q;
   logic [D-1:0]   d;
   logic [D:0]     r;
   logic           s;
   logic [CW-1:0]  cnt;
   logic           ready_r, done_r, dbz_r;
   logic [W-1:0]   quot_r;
   logic [D:0]     rem_r;
   logic           accept;
   logic [D:0]     t, t_sub;

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      t          = {r[D-1:0], mag[W-1]};
      t_sub      = t - {1'b0, d};
      case (state)
         IDLE:    if (bus.start && ready_r) begin
                     accept     = 1'b1;
                     state_next = CALC;
                  end
         CALC:    if (cnt == CW'(W-1)) state_next = FIXUP;
         FIXUP:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset)      state <= IDLE;
      else if (bus.ce) state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mag     <= '0;
         d       <= '0;
         r       <= '0;
         q       <= '0;
         s       <= 1'b0;
         cnt     <= '0;
         ready_r <= 1'b1;
         done_r  <= 1'b0;
         quot_r  <= '0;
         rem_r   <= '0;
         dbz_r   <= 1'b0;
      end else if (bus.ce) begin
         // ready stays low for the cycle carrying done, so results are seen before re-issue
         ready_r <= (state_next == IDLE) && (state != DONE);
         done_r  <= (state == DONE);
         case (state)
            IDLE: if (accept) begin
               mag <= bus.din0[W-1] ? W'(-bus.din0) : bus.din0;
               d   <= bus.din1;
               s   <= bus.din0[W-1];
               r   <= '0;
               q   <= '0;
               cnt <= '0;
            end
            CALC: begin
               mag <= {mag[W-2:0], 1'b0};
               if (t >= {1'b0, d}) begin
                  r <= t_sub;
                  q <= {q[W-2:0], 1'b1};
               end else begin
                  r <= t;
                  q <= {q[W-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
            end
            FIXUP: begin
               if (d == '0) begin
                  quot_r <= '1;
                  rem_r  <= '0;
                  dbz_r  <= 1'b1;
               end else begin
                  quot_r <= s ? W'(-q) : q;
                  rem_r  <= s ? (D+1)'(-r) : r;
                  dbz_r  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready       = ready_r;
   assign bus.done        = done_r;
   assign bus.quot        = quot_r;
   assign bus.rem         = rem_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.state_dbg   = state;
endmodule

// File: tb/tb_sample_div_seq_s11_u6.sv
// Scoreboard bench for sample_div_seq_s11_u6: driver pushes expected results, monitor checks on done.
module tb_sample_div_seq_s11_u6;
   localparam int EW = 11 + 7 + 1 + 8 + 8;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   logic [EW-1:0] exp_q[$];

   sample_div_seq_s11_u6_if bus ();
   sample_div_seq_s11_u6 dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, cycles=%0d required=finish", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference: plain integer division truncates toward zero, % takes the dividend's sign
   function automatic logic [EW-1:0] model(input logic [10:0] a, input logic [5:0] b,
                                           input int lat, input int width);
      int   sa, ub, qv, rv;
      logic dz;
      sa = $signed(a);
      ub = int'(b);
      if (ub == 0) begin
         qv = -1; rv = 0; dz = 1'b1;
      end else begin
         qv = sa / ub; rv = sa % ub; dz = 1'b0;
      end
      return {11'(qv), 7'(rv), dz, 8'(lat), 8'(width)};
   endfunction

   initial begin
      logic          done_q;
      logic          active;
      int            width_cnt;
      logic [EW-1:0] cur;
      done_q = 1'b0; active = 1'b0; width_cnt = 0; cur = '0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            done_q = 1'b0; active = 1'b0;
            continue;
         end
         if (bus.done && !done_q) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_done: got done=1 expected no pending result");
               active = 1'b0;
            end else begin
               cur = exp_q.pop_front();
               check("quot", int'(bus.quot), int'(cur[34:24]));
               check("rem", int'(bus.rem), int'(cur[23:17]));
               check("div_by_zero", int'(bus.div_by_zero), int'(cur[16]));
               check("latency", cyc - acc_cyc, int'(cur[15:8]));
               active = 1'b1;
               width_cnt = 1;
            end
         end else if (bus.done && active) begin
            width_cnt++;
         end else if (!bus.done && done_q && active) begin
            check("done_width", width_cnt, int'(cur[7:0]));
            active = 1'b0;
         end
         done_q = bus.done;
      end
   end

   task automatic wait_ready();
      int guard = 0;
      while (!bus.ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.ready) begin
         n_cmp++; n_err++;
         $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
      end
   endtask

   task automatic run_div(input logic [10:0] a, input logic [5:0] b, input int calc_stalls,
                          input int done_stall, input bit inject);
      int guard;
      wait_ready();
      bus.din0 = a; bus.din1 = b; bus.start = 1'b1;
      @(posedge clk); #1;
      acc_cyc = cyc;
      bus.start = 1'b0;
      exp_q.push_back(model(a, b, 13 + calc_stalls, 1 + done_stall));
      @(negedge clk);
      for (int i = 0; i < calc_stalls; i++) begin
         repeat ($urandom_range(0, 1)) @(negedge clk);
         bus.ce = 1'b0;
         @(negedge clk);
         bus.ce = 1'b1;
      end
      if (inject) begin
         bus.din0 = 11'h60C; bus.din1 = 6'd3; bus.start = 1'b1;
         repeat (2) @(negedge clk);
         bus.start = 1'b0;
      end
      guard = 0;
      while (!bus.done && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.done) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout: got done=0 expected done within 60 cycles");
         void'(exp_q.pop_back());
      end else if (done_stall > 0) begin
         bus.ce = 1'b0;
         repeat (done_stall) @(negedge clk);
         bus.ce = 1'b1;
      end
   endtask

   initial begin
      reset = 1'b0;
      bus.ce = 1'b0; bus.start = 1'b0; bus.din0 = '0; bus.din1 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("reset_ready", int'(bus.ready), 1);
      check("reset_done", int'(bus.done), 0);
      check("reset_quot", int'(bus.quot), 0);
      check("reset_rem", int'(bus.rem), 0);
      check("reset_dbz", int'(bus.div_by_zero), 0);
      bus.ce = 1'b1;

      run_div(11'd100, 6'd7, 0, 0, 0);
      run_div(-11'sd100, 6'd7, 0, 0, 0);
      run_div(11'd1023, 6'd63, 0, 0, 0);
      run_div(11'h400, 6'd1, 0, 0, 0);
      run_div(11'd0, 6'd5, 0, 0, 0);
      run_div(11'd5, 6'd0, 0, 0, 0);
      run_div(-11'sd777, 6'd13, 3, 4, 0);
      run_div(11'd100, 6'd7, 0, 0, 1);

      // Abort a divide midway through CALC
      wait_ready();
      bus.din0 = 11'd100; bus.din1 = 6'd7; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort_ready", int'(bus.ready), 1);
      check("abort_done", int'(bus.done), 0);
      check("abort_quot", int'(bus.quot), 0);
      check("abort_rem", int'(bus.rem), 0);
      check("abort_dbz", int'(bus.div_by_zero), 0);
      repeat (20) @(negedge clk);
      run_div(11'd100, 6'd7, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         logic [10:0] a;
         logic [5:0]  b;
         a = 11'($urandom_range(0, 2047));
         b = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         run_div(a, b, $urandom_range(0, 3), $urandom_range(0, 2), 0);
      end

      repeat (10) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
